vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It is the stage directly upstream of the sprite/background renderers, which consume `DrawX`, `DrawY` and `blank`. Sync outputs are delayed through a short pipeline so that `hs`/`vs` stay aligned with the renderers' registered colour outputs. It also provides a frame-start strobe and a frame counter, which downstream game logic uses as its per-frame tick.

---
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters, visible-area decode,
// delayed active-low syncs, frame-start strobe and a frame counter.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 still decodes
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]            hc, vc;
  logic [10:0]           hc_x, vc_x;
  logic                  hs_raw, vs_raw;
  logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      frame_count <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      if (vc == V_LAST) begin
        vc          <= '0;
        frame_count <= frame_count + 16'd1;
      end else begin
        vc <= vc + 10'd1;
      end
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign hc_x = {1'b0, hc};
  assign vc_x = {1'b0, vc};

  always_comb begin
    hs_raw = !((hc_x >= HS_START) && (hc_x < HS_END));
    vs_raw = !((vc_x >= VS_START) && (vc_x < VS_END));
  end

  // Delay matches the renderers' colour latency; reset loads idle-high so
  // no truncated pulse leaks out after a mid-frame reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign blank       = (hc_x < H_VIS) && (vc_x < V_VIS);
  assign frame_start = (hc == 10'd0) && (vc == 10'd0);
  assign hs          = hs_pipe[SYNC_DELAY-1];
  assign vs          = vs_pipe[SYNC_DELAY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default instance for line-level checks, two
// shrunken-raster instances (delay 1 and 3) for frame-level checks.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;  // 30
  localparam int VT = VV + VF + VS + VB;  // 15

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    obs_t b;
    obs_t c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_blank, a_hs, a_vs, a_fs, b_blank, b_hs, b_vs, b_fs, c_blank, c_hs, c_vs, c_fs;
  logic [15:0] a_fc, b_fc, c_fc;

  vga_timing_gen dut_a (
    .vga_clk(clk), .reset(reset), .DrawX(a_x), .DrawY(a_y), .blank(a_blank),
    .hs(a_hs), .vs(a_vs), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_DELAY(1)
  ) dut_b (
    .vga_clk(clk), .reset(reset), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
    .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_DELAY(3)
  ) dut_c (
    .vga_clk(clk), .reset(reset), .DrawX(c_x), .DrawY(c_y), .blank(c_blank),
    .hs(c_hs), .vs(c_vs), .frame_start(c_fs), .frame_count(c_fc)
  );

  obs_t b_obs, c_obs;
  assign b_obs = {b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_fc};
  assign c_obs = {c_x, c_y, c_blank, c_hs, c_vs, c_fs, c_fc};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs t cycles after the last reset edge, from elapsed time
  function automatic obs_t model(input int t, input int d);
    obs_t o;
    int line, ts, sh, sv;
    line    = t / HT;
    o.x     = 10'(t % HT);
    o.y     = 10'(line % VT);
    o.fc    = 16'((line / VT) % 65536);
    o.blank = (int'(o.x) < HV) && (int'(o.y) < VV);
    o.fs    = (o.x == 10'd0) && (o.y == 10'd0);
    ts = t - d;
    if (ts < 0) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      sh = ts % HT;
      sv = (ts / HT) % VT;
      o.hs = !(sh >= HV + HF && sh < HV + HF + HS);
      o.vs = !(sv >= VV + VF && sv < VV + VF + VS);
    end
    return o;
  endfunction

  exp_t q[$];
  int t = -1;

  always @(posedge clk) begin : sb_push
    int tn;
    tn = reset ? 0 : ((t >= 0) ? t + 1 : -1);
    t <= tn;
    if (tn >= 0) q.push_back('{model(tn, 1), model(tn, 3)});
  end

  always @(negedge clk) begin : sb_pop
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_delay1", b_obs, e.b);
      chk("sb_delay3", c_obs, e.c);
    end
  end

  initial begin
    int lo, first, last, hs656, hs753, k;
    int vlo, vfirst, vlast, blank_bad, cfirst;

    // reset release
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_xy",    {a_x, a_y}, 20'd0);
    chk("rst_flags", {a_blank, a_hs, a_vs, a_fs}, 4'b1111);
    chk("rst_fc",    a_fc, 16'd0);
    reset = 1'b0;
    repeat (640) @(negedge clk);
    chk("x640",       a_x, 10'd640);
    chk("blank_x640", a_blank, 1'b0);
    repeat (160) @(negedge clk);
    chk("line1_xy", {a_x, a_y}, {10'd0, 10'd1});
    chk("line1_fs", a_fs, 1'b0);

    // horizontal sync over one full default line
    lo = 0; first = -1; last = -1; hs656 = -1; hs753 = -1;
    for (int i = 0; i < 800; i++) begin
      if (a_hs === 1'b0) begin
        lo++;
        if (first < 0) first = int'(a_x);
        last = int'(a_x);
      end
      if (a_x == 10'd656) hs656 = int'(a_hs);
      if (a_x == 10'd753) hs753 = int'(a_hs);
      @(negedge clk);
    end
    chk("hs_low_count", lo, 96);
    chk("hs_first_low", first, 657);
    chk("hs_last_low",  last, 752);
    chk("hs_at_656",    hs656, 1);
    chk("hs_at_753",    hs753, 1);

    // frame wrap on the shrunken raster
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (HT * VT) @(negedge clk);
    chk("wrap_xy", {b_x, b_y, b_fs}, {10'd0, 10'd0, 1'b1});
    chk("wrap_fc", b_fc, 16'd1);
    chk("wrap_fc_d3", c_fc, 16'd1);

    // vertical sync and blanking over one shrunken frame
    vlo = 0; vfirst = -1; vlast = -1; blank_bad = 0; cfirst = -1;
    for (int i = 0; i < HT * VT; i++) begin
      if (b_vs === 1'b0) begin
        vlo++;
        if (vfirst < 0) vfirst = int'(b_y) * 1000 + int'(b_x);
        vlast = int'(b_y) * 1000 + int'(b_x);
      end
      if (c_vs === 1'b0 && cfirst < 0) cfirst = int'(c_y) * 1000 + int'(c_x);
      if (int'(b_y) >= VV && b_blank !== 1'b0) blank_bad++;
      @(negedge clk);
    end
    chk("vs_low_count", vlo, 2 * HT);
    chk("vs_first_low", vfirst, 10 * 1000 + 1);
    chk("vs_last_low",  vlast, 12 * 1000 + 0);
    chk("blank_vbl",    blank_bad, 0);
    chk("vs_first_d3",  cfirst, 10 * 1000 + 3);

    // mid-frame reset while vs is low
    k = 0;
    while (!(b_x == 10'd9 && b_y == 10'd10) && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("reach_mid", (b_x == 10'd9 && b_y == 10'd10), 1'b1);
    chk("mid_vs_low", b_vs, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_xy",   {b_x, b_y}, 20'd0);
    chk("mid_rst_sync", {b_hs, b_vs}, 2'b11);
    chk("mid_rst_fc",   b_fc, 16'd0);
    k = 0;
    while (b_vs !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("vs_refall", k, (VV + VF) * HT + 1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
